// File: rtl/filter_scan_ctrl_pkg.sv
// Shared constants and helpers for the deglitch filter scheduler.
package filter_scan_ctrl_pkg;

  // 50 MHz clock, 0.6 us tick
  localparam int PRESCALE_DEF    = 30;
  localparam int TICK_PERIOD_NS  = 600;
  // 200 ticks = 120 us qualification window
  localparam int FILTER_TIME_DEF = 200;
  // timer / deadline width
  localparam int TW_DEF          = 8;

  // Width of the round-robin scan pointer; at least one bit even for one channel.
  function automatic int ptr_width(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/filter_edge_sync.sv
// Per-channel front end: 2-flop synchroniser plus a previous-level flop.
// o_level is the synchronised input, o_edge flags a change since last clk.
module filter_edge_sync
  import filter_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_level,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronise the raw input and remember the previous synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_level = r_sync2;
  assign o_edge  = r_sync2 ^ r_prev;

endmodule

// File: rtl/filter_scan_ctrl.sv
// Deglitch filter scheduler: shared tick/timebase, per-channel deadlines and
// a single time-shared compare driven by a round-robin scan pointer.
module filter_scan_ctrl
  import filter_scan_ctrl_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int PRESCALE    = PRESCALE_DEF,
  parameter int FILTER_TIME = FILTER_TIME_DEF,
  parameter int TW          = TW_DEF,
  localparam int PW         = ptr_width(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH_NUM-1:0] sin,
  output logic [CH_NUM-1:0] sout,
  output logic [TW-1:0]     timer,
  output logic              tick,
  output logic              busy,
  output logic              upd_valid,
  output logic [PW-1:0]     upd_ch
);

  localparam int PSW = $clog2(PRESCALE);

  logic [PSW-1:0]    r_presc;
  logic [TW-1:0]     r_timer;
  logic              r_tick;
  logic [PW-1:0]     r_ptr;
  logic [CH_NUM-1:0] r_pending;
  logic [CH_NUM-1:0] r_target;
  logic [CH_NUM-1:0] r_sout;
  logic [TW-1:0]     r_deadline [CH_NUM];
  logic              r_busy;
  logic              r_upd_valid;
  logic [PW-1:0]     r_upd_ch;

  logic [CH_NUM-1:0] w_level;
  logic [CH_NUM-1:0] w_edge;
  logic              w_tc;
  logic              w_hit;
  logic              w_fire;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_sync
    filter_edge_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_din   (sin[g]),
      .o_level (w_level[g]),
      .o_edge  (w_edge[g])
    );
  end

  assign w_tc = (r_presc == PSW'(PRESCALE - 1));

  // Prescaler and timebase; free-running, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_timer <= '0;
      r_tick  <= 1'b0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_timer <= r_timer + TW'(1);
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PSW'(1);
      r_tick  <= 1'b0;
    end
  end

  // Scan pointer visits one channel per clk, wrapping at CH_NUM-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_ptr == PW'(CH_NUM - 1)) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + PW'(1);
    end
  end

  // Shared compare: scanned channel has reached its deadline; an edge on the
  // same channel in the same clk suppresses the output update.
  always_comb begin
    w_hit  = r_pending[r_ptr] && (r_timer == r_deadline[r_ptr]);
    w_fire = en && w_hit && !w_edge[r_ptr] && (r_target[r_ptr] != r_sout[r_ptr]);
  end

  // Per-channel deadline/pending/target bookkeeping; edges take priority
  // over a concurrent deadline match so glitches restart the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_target  <= '0;
      r_sout    <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_deadline[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!en) begin
          r_pending[i] <= 1'b0;
        end else if (w_edge[i]) begin
          r_deadline[i] <= r_timer + TW'(FILTER_TIME);
          r_target[i]   <= w_level[i];
          r_pending[i]  <= 1'b1;
        end else if (w_hit && (r_ptr == PW'(i))) begin
          r_pending[i] <= 1'b0;
          r_sout[i]    <= r_target[i];
        end
      end
    end
  end

  // Registered status and change strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_upd_valid <= 1'b0;
      r_upd_ch    <= '0;
    end else begin
      r_busy      <= |r_pending;
      r_upd_valid <= w_fire;
      r_upd_ch    <= r_ptr;
    end
  end

  assign sout      = r_sout;
  assign timer     = r_timer;
  assign tick      = r_tick;
  assign busy      = r_busy;
  assign upd_valid = r_upd_valid;
  assign upd_ch    = r_upd_ch;

endmodule

// File: doc/filter_scan_ctrl.md
Name: filter_scan_ctrl

Overview:
Scheduler for the deglitch filters on the serial inverter CPLD. It generates the shared 0.6 us tick and the 8-bit timebase used by the edge-deadline filters. It holds one deadline register per input channel and time-shares a single compare datapath across all channels with a round-robin scan pointer. A channel's output follows its input only after the input has been stable for FILTER_TIME ticks.

Parameters:
CH_NUM, 4, number of filtered channels; legal range 1..PRESCALE.
PRESCALE, 30, clk cycles per timer tick (50 MHz x 0.6 us); must be >= 2.
FILTER_TIME, 200, qualification time in ticks (200 x 0.6 us = 120 us); legal range 1..255.
TW, 8, timer and deadline width.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
en  in  1  filter enable; when low, all pending events are dropped
sin  in  CH_NUM  raw asynchronous channel inputs
sout  out  CH_NUM  filtered outputs, registered
timer  out  TW  free-running tick counter, for debug and monitoring
tick  out  1  one-clk strobe on each timer increment
busy  out  1  high while any channel has a pending event
upd_valid  out  1  one-clk strobe when any sout bit changes
upd_ch  out  clog2(CH_NUM)  index of the channel that changed; valid with upd_valid

Behaviour:
- Reset (rst=1, asynchronous): all registers clear to 0, including sout, timer, prescaler, scan pointer, sync flops, pending, target and deadline. tick, busy and upd_valid are 0.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - At terminal count it wraps to 0, asserts tick for one clk and increments timer mod 2^TW.
  - Runs regardless of en.
- Per-channel front end:
  - 2-flop synchroniser, then a registered previous-level flop.
  - An edge is sync_now != prev.
- Edge handling for channel i (edge detected and en=1):
  - deadline[i] <= timer + FILTER_TIME, truncated to TW bits (wrap-around is intended).
  - target[i] <= new level.
  - pending[i] <= 1.
  - A new edge while pending restarts the deadline and overwrites target. This is the glitch rejection.
- Scan:
  - ptr advances by 1 every clk and wraps from CH_NUM-1 to 0.
  - Channel ptr is evaluated; if pending[ptr]=1 and timer == deadline[ptr], then:
    - pending[ptr] <= 0.
    - If target[ptr] != sout[ptr]: sout[ptr] <= target[ptr]; upd_valid=1 and upd_ch=ptr on the next clk.
    - If target[ptr] == sout[ptr]: pending clears silently and there is no strobe.
  - Because CH_NUM <= PRESCALE, every channel is visited at least once while timer holds any value, so no deadline is missed.
- Simultaneous edge and scan match on the same channel in the same clk: the edge wins. Deadline reloads, pending stays 1, sout is unchanged.
- Latency from input edge to sout:
  - Nominal: FILTER_TIME ticks.
  - Minimum: (FILTER_TIME-1) x PRESCALE + 3 clks (tick phase).
  - Maximum: FILTER_TIME x PRESCALE + 3 + CH_NUM clks. The 3 covers sync plus prev; the scan adds up to CH_NUM.
- Enable:
  - en=0 clears all pending bits and ignores edges; sout holds its value.
  - While en=0, prev still tracks the synchronised input, so no spurious edge fires on en rising.
  - After en rises, a level that differs from sout is not re-qualified until the next input edge.
- busy = OR of pending, registered.
- Only one sout bit can change per clk, so upd_ch is unambiguous.

Decomposition:
- Shared package: FILTER_TIME and PRESCALE defaults, TW, tick period constant, and the CH_NUM-to-pointer-width function.
- One sub-module, filter_edge_sync: per-channel 2-flop synchroniser plus previous-level flop and edge/level outputs, instantiated CH_NUM times.
- Deadline, pending, target and scan logic stay in the top level.

Test Plan:
(Defaults unless stated: PRESCALE=30, FILTER_TIME=200, CH_NUM=4, en=1.)
- Clean step: sin[0] 0->1 and held. sout[0] rises within [5973, 6007] clks of the edge. One upd_valid with upd_ch=0. busy is high across the interval.
- Glitch: sin[1] high for 100 ticks (3000 clks), then low. sout[1] stays 0, no upd_valid, busy clears about 200 ticks after the falling edge.
- Wrap-around: force an edge on sin[2] when timer=100. deadline=44 after the wrap; sout[2] changes when timer reaches 44 following its wrap to 0; no early fire.
- Simultaneous edges: all 4 sin bits rise in the same clk. All sout bits rise within 4 consecutive clks of the deadline match, with four upd_valid strobes whose upd_ch values are distinct.
- Reset mid-pending: assert rst 100 ticks after a rising edge on sin[3]. All outputs are 0 immediately (asynchronously). After release, sout[3] rises about 200 ticks later, because the held-high input is re-seen as a new edge.
- Enable drop: en=0 at 150 ticks into a pending event. No sout change, busy drops, timer keeps incrementing.
